// File: rtl/dzcpu_ucode_seq.sv
// dzcpu_ucode_seq: microcode sequencer. Fetches an opcode byte, dispatches
// through the main (or CB) LUT into the uop ROM, and steps the micro-PC
// according to each uop's flow field until the flow ends or runs too long.
`timescale 1ns/1ps

module dzcpu_ucode_seq #(
  parameter logic [4:0] P_JCB_OP   = 5'd20,
  parameter logic [7:0] P_MAX_FLOW = 8'd32
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [7:0]  iMemData,
  input  logic        iMemReady,
  input  logic        iFlagZ,
  input  logic        iStall,
  input  logic [7:0]  iLutIdx,
  input  logic [7:0]  iCbLutIdx,
  input  logic [11:0] iUop,
  output logic        oMemRead,
  output logic [7:0]  oLutMop,
  output logic [7:0]  oCbLutMop,
  output logic [7:0]  oUopAddr,
  output logic        oUopValid,
  output logic [4:0]  oUopOp,
  output logic [3:0]  oUopOperand,
  output logic        oIncPc,
  output logic        oInstrDone,
  output logic        oUcodeErr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DISPATCH,
    S_EXEC,
    S_CBDISP
  } state_t;

  localparam logic [2:0] FLOW_OP        = 3'd0;
  localparam logic [2:0] FLOW_INC       = 3'd1;
  localparam logic [2:0] FLOW_EOF       = 3'd2;
  localparam logic [2:0] FLOW_INC_EOF   = 3'd3;
  localparam logic [2:0] FLOW_INC_EOF_Z = 3'd4;

  state_t     state;
  logic [7:0] upc;
  logic [7:0] flow_cnt;

  logic [2:0] flow;
  logic [4:0] op;
  logic       in_exec;
  logic       run;
  logic       flow_inc;
  logic       flow_end;
  logic       flow_bad;
  logic       limit_hit;
  logic       abort;
  logic       jump_cb;

  assign flow = iUop[11:9];
  assign op   = iUop[8:4];

  // Decode the flow field of the uop currently presented by the ROM.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    flow_inc = 1'b0;
    flow_end = 1'b0;
    flow_bad = 1'b0;
    case (flow)
      FLOW_OP:        begin end
      FLOW_INC:       flow_inc = 1'b1;
      FLOW_EOF:       flow_end = 1'b1;
      FLOW_INC_EOF:   begin flow_inc = 1'b1; flow_end = 1'b1; end
      FLOW_INC_EOF_Z: begin flow_inc = 1'b1; flow_end = iFlagZ; end
      default:        flow_bad = 1'b1;
    endcase
  end

  // A uop that ends its flow on the limit is a normal end; only a
  // non-ending uop at the limit (or an illegal flow) aborts.
  assign limit_hit = ({1'b0, flow_cnt} + 9'd1) >= {1'b0, P_MAX_FLOW};
  assign abort     = flow_bad | (~flow_end & limit_hit);
  assign jump_cb   = (op == P_JCB_OP) & ~flow_end & ~abort;

  assign in_exec     = (state == S_EXEC);
  assign run         = in_exec & ~iStall;
  assign oMemRead    = (state == S_FETCH);
  assign oUopAddr    = upc;
  assign oUopValid   = in_exec;
  assign oUopOp      = in_exec ? op : 5'd0;
  assign oUopOperand = in_exec ? iUop[3:0] : 4'd0;
  assign oIncPc      = run & flow_inc;
  assign oInstrDone  = run & (flow_end | abort);

  // Sequencer state machine: fetch, dispatch, execute, CB redirect.
  always_ff @(posedge iClock or posedge iReset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (iReset) begin
      state     <= S_IDLE;
      upc       <= 8'd0;
      flow_cnt  <= 8'd0;
      oLutMop   <= 8'd0;
      oCbLutMop <= 8'd0;
      oUcodeErr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (iMemReady) begin
            oLutMop <= iMemData;
            state   <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          upc      <= iLutIdx;
          flow_cnt <= 8'd0;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          if (!iStall) begin
            flow_cnt <= flow_cnt + 8'd1;
            if (flow_end || abort) begin
              if (abort) oUcodeErr <= 1'b1;
              state <= S_FETCH;
            end else if (jump_cb) begin
              oCbLutMop <= iMemData;
              state     <= S_CBDISP;
            end else begin
              upc <= upc + 8'd1;
            end
          end
        end
        S_CBDISP: begin
          upc   <= iCbLutIdx;
          state <= S_EXEC;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
